seq_mul_ctrl: RTL and testbench

- Sequencer that performs a 32x32 -> 64-bit multiply, signed or unsigned, by time-multiplexing a single instance of the team's 32-bit ripple-carry adder (adder_32) over a fixed 36-cycle schedule.
- The block owns the FSM, the operand and product registers, the adder operand muxes and a valid/ready handshake on both sides.
- It sits beside the ALU as the multi-cycle MUL unit.

---
 rtl/seq_mul_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_seq_mul_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mul_ctrl
//   Multi-cycle 32x32 -> 64-bit multiplier, signed or unsigned. It reuses one
//   32-bit ripple-carry adder (adder_32) over a fixed 36-cycle schedule:
//     IDLE -> ABS_A -> ABS_B -> ITER x32 -> NEG_LO -> NEG_HI -> DONE
//   The operands are turned into magnitudes, multiplied with shift-add, and the
//   product is negated when the operand signs differ.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   op_a, op_b, op_signed multiplicand, multiplier, two's-complement select
//   abort                 cancel the in-flight operation (ignored in IDLE)
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   result                64-bit product, stable while in DONE
//   busy                  high in every state except IDLE
// -----------------------------------------------------------------------------

// Team ripple-carry adder, one bit per stage.
module adder_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    always_comb begin : ripple
        logic c;
        sum = '0;
        c   = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module seq_mul_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic               op_signed,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               busy
);
    // The schedule and the adder are both hard-wired to 32 bits.
    if (WIDTH != 32) begin : g_bad_width
        $error("seq_mul_ctrl: WIDTH must be 32");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ABS_A  = 3'd1,
        ABS_B  = 3'd2,
        ITER   = 3'd3,
        NEG_LO = 3'd4,
        NEG_HI = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic               neg_q, neg_d;
    logic               cflag_q, cflag_d;

    // Shared adder operand muxes.
    logic [WIDTH-1:0]   add_a, add_b, add_sum;
    logic               add_cin, add_cout;

    adder_32 u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        signed_d = signed_q;
        neg_d    = neg_q;
        cflag_d  = cflag_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;

        case (state_q)
            IDLE: begin
                // Operands are only looked at on the accept edge, so X on
                // them at other times never reaches the registers.
                if (in_valid) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    signed_d = op_signed;
                    state_d  = ABS_A;
                end
            end
            ABS_A: begin
                add_a   = ~a_q;
                add_cin = 1'b1;
                if (signed_q && a_q[WIDTH-1]) a_d = add_sum;
                neg_d   = signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                state_d = ABS_B;
            end
            ABS_B: begin
                add_a   = ~b_q;
                add_cin = 1'b1;
                if (signed_q && b_q[WIDTH-1]) b_d = add_sum;
                p_d     = {{WIDTH{1'b0}}, (signed_q && b_q[WIDTH-1]) ? add_sum : b_q};
                cnt_d   = 5'd31;
                state_d = ITER;
            end
            ITER: begin
                // Shift-add step; the adder carry becomes the new top bit.
                add_a = p_q[2*WIDTH-1:WIDTH];
                add_b = a_q;
                if (p_q[0]) p_d = {add_cout, add_sum, p_q[WIDTH-1:1]};
                else        p_d = {1'b0, p_q[2*WIDTH-1:1]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) state_d = NEG_LO;
            end
            NEG_LO: begin
                // 64-bit negate split in halves; cflag carries the +1 upward.
                add_a   = ~p_q[WIDTH-1:0];
                add_cin = 1'b1;
                if (neg_q) begin
                    p_d[WIDTH-1:0] = add_sum;
                    cflag_d        = add_cout;
                end else begin
                    cflag_d        = 1'b0;
                end
                state_d = NEG_HI;
            end
            NEG_HI: begin
                add_a   = ~p_q[2*WIDTH-1:WIDTH];
                add_cin = cflag_q;
                if (neg_q) p_d[2*WIDTH-1:WIDTH] = add_sum;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over every transition except in IDLE, where it is ignored.
        if (abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            neg_q    <= 1'b0;
            cflag_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            neg_q    <= neg_d;
            cflag_q  <= cflag_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = p_q;

endmodule

// File: tb/tb_seq_mul_ctrl.sv
module tb_seq_mul_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_signed = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    int checks = 0;
    int failures = 0;

    seq_mul_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_signed (op_signed),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one request, accept on the next edge, then scramble the operand
    // inputs to show later changes are ignored. Returns #1 after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                            input bit keep_valid);
        @(negedge clk);
        chk("in_ready_before_accept", {63'b0, in_ready}, 64'd1);
        op_a = a; op_b = b; op_signed = s; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = keep_valid;
        op_a      = $urandom;
        op_b      = $urandom;
        op_signed = ~s;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("in_ready_after_consume", {63'b0, in_ready}, 64'd1);
        chk("out_valid_after_consume", {63'b0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp);
        int e;
        start_op(a, b, s, 1'b0);
        wait_done(e);
        chk({nm, "_latency"}, 64'(e), 64'd36);
        chk({nm, "_result"}, result, exp);
        consume();
    endtask

    initial begin
        int e;
        bit seen;
        logic [63:0] held;
        logic [31:0] ra, rb;
        logic        rs;
        logic signed [63:0] sa, sb;
        logic [63:0] rexp;

        vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
        vecs[1]  = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFFFFFFFFEB};
        vecs[2]  = '{32'h00000007, 32'hFFFFFFFD, 1'b1, 64'hFFFFFFFFFFFFFFEB};
        vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000};
        vecs[4]  = '{32'h80000000, 32'h00000002, 1'b0, 64'h0000000100000000};
        vecs[5]  = '{32'h80000000, 32'h00000002, 1'b1, 64'hFFFFFFFF00000000};
        vecs[6]  = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000};
        vecs[7]  = '{32'h00000005, 32'h00000006, 1'b0, 64'h000000000000001E};
        vecs[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
        vecs[9]  = '{32'h00010000, 32'h00010000, 1'b0, 64'h0000000100000000};
        vecs[10] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFFFFFFFFFF};
        vecs[11] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 64'h00000000FFFFFFFF};
        vecs[12] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};

        // Reset state
        #2;
        chk("reset_result", result, 64'd0);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);

        // Back-pressure, with in_valid held high through the operation
        start_op(32'h00000003, 32'h00000004, 1'b0, 1'b1);
        chk("bp_busy_after_accept", {63'b0, busy}, 64'd1);
        wait_done(e);
        chk("bp_latency", 64'(e), 64'd36);
        held = result;
        chk("bp_result", held, 64'd12);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (!out_valid || result !== held || in_ready) seen = 1'b1;
        end
        chk("bp_stable_10_cycles", {63'b0, seen}, 64'd0);
        consume();
        @(posedge clk);
        #1;
        chk("bp_no_second_accept", {63'b0, busy}, 64'd0);

        // Abort together with out_ready in DONE
        start_op(32'h00000009, 32'h00000009, 1'b0, 1'b0);
        wait_done(e);
        chk("abort_done_result", result, 64'd81);
        @(negedge clk);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0; out_ready = 1'b0;
        chk("abort_done_idle", {63'b0, in_ready}, 64'd1);
        chk("abort_done_no_valid", {63'b0, out_valid}, 64'd0);

        // Abort at ITER cycle 10
        start_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_iter_idle", {63'b0, in_ready}, 64'd1);
        chk("abort_iter_not_busy", {63'b0, busy}, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_iter_never_valid", {63'b0, seen}, 64'd0);
        run_op("after_abort", 32'd5, 32'd6, 1'b0, 64'd30);

        // Abort in IDLE is ignored: accept with abort high
        @(negedge clk);
        op_a = 32'd7; op_b = 32'd8; op_signed = 1'b0; in_valid = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; abort = 1'b0;
        chk("idle_abort_accepted", {63'b0, busy}, 64'd1);
        wait_done(e);
        chk("idle_abort_latency", 64'(e), 64'd36);
        chk("idle_abort_result", result, 64'd56);
        consume();

        // Asynchronous reset mid-ITER
        start_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_result", result, 64'd0);
        chk("async_rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("async_rst_busy", {63'b0, busy}, 64'd0);
        chk("async_rst_out_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        chk("async_rst_discarded", {63'b0, seen}, 64'd0);

        // Short random batch against a 64-bit reference multiply
        for (int n = 0; n < 40; n++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            if (n % 8 == 0) ra = 32'h80000000;
            sa = rs ? {{32{ra[31]}}, ra} : {32'b0, ra};
            sb = rs ? {{32{rb[31]}}, rb} : {32'b0, rb};
            rexp = 64'(sa * sb);
            run_op($sformatf("rand%0d", n), ra, rb, rs, rexp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
